// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: byte stream from the PS/2 keyboard receiver to the core.
// The receiver drives data/valid and the consumer drives ready.
// With PS2_KBD_EXT_DECODE_EN defined, the extended/release flags travel
// alongside each byte.
interface ps2_kbd_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
`ifdef PS2_KBD_EXT_DECODE_EN
   logic       rx_ext;
   logic       rx_release;

   modport master (output rx_data, rx_valid, rx_ext, rx_release, input rx_ready);
   modport slave  (input rx_data, rx_valid, rx_ext, rx_release, output rx_ready);
`else
   modport master (output rx_data, rx_valid, input rx_ready);
   modport slave  (input rx_data, rx_valid, output rx_ready);
`endif
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver.
// The receiver synchronises and deglitches ps2_clk/ps2_data, then deserialises
// 11-bit frames (start, 8 data bits LSB-first, odd parity, stop). Good bytes are
// buffered in a first-word-fall-through FIFO.
// Optional feature macro: PS2_KBD_EXT_DECODE_EN folds the E0/F0 prefixes into
// rx_ext/rx_release flags that are stored with each byte.
module ps2_kbd_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_BITS      = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   ps2_kbd_rx_if.master bus,
   output logic         rx_overflow,
   output logic         err_parity,
   output logic         err_frame,
   output logic [7:0]   err_count,
   output logic         busy
);

`ifdef PS2_KBD_EXT_DECODE_EN
   localparam int W = 10;
`else
   localparam int W = 8;
`endif
   localparam int          DEPTH     = 2**FIFO_BITS;
   localparam logic [3:0]  FLT_LAST  = 4'(FILTER_LEN - 1);
   localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]  clk_sync, data_sync;
   logic [1:0]  flt;                 // [0] = filtered clk, [1] = filtered data
   logic [3:0]  flt_cnt [2];
   logic        flt_clk_q;
   logic        fe, d;
   state_t      state, state_n;
   logic [7:0]  shreg;
   logic [2:0]  bit_cnt;
   logic        acc, parity_ok;
   logic [16:0] tmo_cnt;
   logic        tmo_hit;
   logic        ev_frame, ev_par, ev_ovf, byte_done;
   logic        push_q;
   logic [W-1:0] push_word;
   logic [W-1:0] mem [DEPTH];
   logic [FIFO_BITS:0] wptr, rptr;
   logic        empty, full, pop, wr_en;
   logic [W-1:0] head;

   // Two-flop synchronisers; both lines idle high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Counter filters: a line flips after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flt       <= 2'b11;
         flt_clk_q <= 1'b1;
         for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
      end else begin
         flt_clk_q <= flt[0];
         for (int i = 0; i < 2; i++) begin
            if ((i == 0 ? clk_sync[1] : data_sync[1]) == flt[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FLT_LAST) begin
               flt[i]     <= ~flt[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign fe      = flt_clk_q & ~flt[0];
   assign d       = flt[1];
   assign tmo_hit = (state != S_IDLE) && !fe && (tmo_cnt == TMO_LIMIT);

   // Frame FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Frame FSM next state and per-frame verdicts.
   always_comb begin
      // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
      state_n   = state;
      ev_frame  = 1'b0;
      ev_par    = 1'b0;
      byte_done = 1'b0;
      if (tmo_hit) begin
         state_n  = S_IDLE;
         ev_frame = 1'b1;
      end else if (fe) begin
         unique case (state)
            S_IDLE:   if (!d) state_n = S_DATA; else ev_frame = 1'b1;
            S_DATA:   if (bit_cnt == 3'd7) state_n = S_PARITY;
            S_PARITY: state_n = S_STOP;
            S_STOP: begin
               state_n = S_IDLE;
               if (!d)             ev_frame  = 1'b1;
               else if (!parity_ok) ev_par   = 1'b1;
               else                byte_done = 1'b1;
            end
            default:  state_n = S_IDLE;
         endcase
      end
   end

   // Deserialiser, parity accumulator and inter-edge timeout counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         acc       <= 1'b1;
         parity_ok <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         tmo_cnt <= (state == S_IDLE || fe) ? 17'd0 : tmo_cnt + 17'd1;
         if (fe) begin
            unique case (state)
               S_IDLE: begin
                  bit_cnt <= '0;
                  acc     <= 1'b1;
               end
               S_DATA: begin
                  shreg   <= {d, shreg[7:1]};
                  acc     <= acc ^ d;
                  bit_cnt <= bit_cnt + 3'd1;
               end
               S_PARITY: parity_ok <= ~(acc ^ d);
               default: ;
            endcase
         end
      end
   end

`ifdef PS2_KBD_EXT_DECODE_EN
   logic ext_flag, rel_flag;

   // Prefix folding: E0/F0 set flags; the next byte is pushed with them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_q    <= 1'b0;
         push_word <= '0;
         ext_flag  <= 1'b0;
         rel_flag  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (ev_frame || ev_par || ev_ovf) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
         end
         if (byte_done) begin
            if (shreg == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (shreg == 8'hF0) begin
               rel_flag <= 1'b1;
            end else begin
               push_q    <= 1'b1;
               push_word <= {ext_flag, rel_flag, shreg};
               ext_flag  <= 1'b0;
               rel_flag  <= 1'b0;
            end
         end
      end
   end
`else
   // Every good byte is queued for the FIFO one cycle after the stop bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_q    <= 1'b0;
         push_word <= '0;
      end else begin
         push_q <= byte_done;
         if (byte_done) push_word <= shreg;
      end
   end
`endif

   assign empty  = (wptr == rptr);
   assign full   = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                   (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
   assign pop    = !empty && bus.rx_ready;
   assign wr_en  = push_q && (!full || pop);
   assign ev_ovf = push_q && full && !pop;

   // FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; entries are only visible once written, and output is gated while empty.
      if (wr_en) mem[wptr[FIFO_BITS-1:0]] <= push_word;
   end

   // FIFO pointers, each with an extra wrap bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
      end
   end

   assign head          = mem[rptr[FIFO_BITS-1:0]];
   assign bus.rx_valid  = !empty;
   assign bus.rx_data   = empty ? 8'h00 : head[7:0];
`ifdef PS2_KBD_EXT_DECODE_EN
   assign bus.rx_ext     = !empty && head[9];
   assign bus.rx_release = !empty && head[8];
`endif
   assign busy = (state != S_IDLE);

   // Error pulses and the saturating event counter, updated on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         rx_overflow <= 1'b0;
         err_count   <= '0;
      end else begin
         err_parity  <= ev_par;
         err_frame   <= ev_frame;
         rx_overflow <= ev_ovf;
         if ((ev_par || ev_frame || ev_ovf) && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end

endmodule
